// File: rtl/wb_xfer_pkg.sv
// Shared definitions for the Wishbone block-transfer initiator:
// FSM state encoding, completion status codes and a counter-sizing helper.
package wb_xfer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_BUS_ERR = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_xfer_timeout.sv
// Per-beat stall watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT-th consecutive stalled cycle since the last clear.
module wb_xfer_timeout
    import wb_xfer_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int              CW   = ctr_width(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    assign o_expired = i_en && (r_count == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_xfer_initiator.sv
// Wishbone classic initiator running incrementing single-beat bursts of
// req_len words, streaming read data out and write data in.
module wb_xfer_initiator
    import wb_xfer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [15:0]               i_req_len,
    input  logic                      i_req_we,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    output logic [DATA_WIDTH-1:0]     o_rd_data,
    output logic                      o_rd_valid,
    output logic                      o_done,
    output logic [1:0]                o_status,
    output logic [ADDR_WIDTH-1:0]     o_adr,
    output logic [DATA_WIDTH-1:0]     o_dat_w,
    input  logic [DATA_WIDTH-1:0]     i_dat_r,
    output logic                      o_cyc,
    output logic                      o_stb,
    output logic                      o_we,
    output logic [DATA_WIDTH/8-1:0]   o_sel,
    input  logic                      i_ack,
    input  logic                      i_err
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_len;
    logic [15:0]           r_beat;
    logic                  r_we;
    logic [1:0]            r_status;

    logic w_in_bus;
    logic w_stb;
    logic w_ack_ok;
    logic w_err;
    logic w_stall;
    logic w_last;
    logic w_expired;
    logic w_to_clear;

    assign w_in_bus = (r_state == ST_BUS);
    // A write beat only strobes once the stream has data for it.
    assign w_stb    = w_in_bus && (r_we ? i_wr_valid : 1'b1);
    // err wins over a simultaneous ack; both are ignored with stb low.
    assign w_err    = w_stb && i_err;
    assign w_ack_ok = w_stb && i_ack && !i_err;
    assign w_stall  = w_stb && !i_ack && !i_err;
    assign w_last   = (r_beat == r_len - 16'd1);
    assign w_to_clear = (r_state != ST_BUS) || w_ack_ok;

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_status    = r_status;
    assign o_cyc       = w_in_bus;
    assign o_stb       = w_stb;
    assign o_we        = w_in_bus && r_we;
    assign o_sel       = w_in_bus ? '1 : '0;
    assign o_adr       = r_addr;
    assign o_dat_w     = (w_in_bus && r_we) ? i_wr_data : '0;
    assign o_rd_data   = i_dat_r;
    assign o_rd_valid  = w_ack_ok && !r_we;
    assign o_wr_ready  = w_ack_ok && r_we;

    wb_xfer_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_to_clear),
        .i_en      (w_stall),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_we     <= 1'b0;
            r_status <= STATUS_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_addr <= i_req_addr;
                        r_len  <= i_req_len;
                        r_we   <= i_req_we;
                        r_beat <= '0;
                        if (i_req_len == 16'd0) begin
                            r_status <= STATUS_OK;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (w_err) begin
                        r_status <= STATUS_BUS_ERR;
                        r_state  <= ST_DONE;
                    end else if (w_ack_ok) begin
                        r_addr <= r_addr + ADDR_STEP;
                        r_beat <= r_beat + 16'd1;
                        if (w_last) begin
                            r_status <= STATUS_OK;
                            r_state  <= ST_DONE;
                        end
                    end else if (w_expired) begin
                        r_status <= STATUS_TIMEOUT;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_xfer_initiator.sv
// Bench for wb_xfer_initiator: table of transfers against a behavioural slave,
// plus write-stall and mid-transfer reset sequences; beats checked via a queue.
module tb_wb_xfer_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic [31:0] wr_data, rd_data, adr, dat_w, dat_r;
    logic        wr_valid, wr_ready, rd_valid, done;
    logic [1:0]  status;
    logic        cyc, stb, we, ack, err;
    logic [3:0]  sel;

    logic        slv_never = 1'b0;
    logic        slv_err_en = 1'b0;
    logic        slv_noise = 1'b0;
    logic [31:0] slv_err_adr = '0;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [31:0] mon_adr, mon_dat;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        logic        we;
        logic        err_en;
        logic [31:0] err_adr;
        logic        never;
        logic [1:0]  exp_status;
        int          exp_beats;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    wb_xfer_initiator #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_len   (req_len),
        .i_req_we    (req_we),
        .i_wr_data   (wr_data),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_done      (done),
        .o_status    (status),
        .o_adr       (adr),
        .o_dat_w     (dat_w),
        .i_dat_r     (dat_r),
        .o_cyc       (cyc),
        .o_stb       (stb),
        .o_we        (we),
        .o_sel       (sel),
        .i_ack       (ack),
        .i_err       (err)
    );

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return a ^ 32'hC3C3_5A5A;
    endfunction

    function automatic logic [31:0] wdata(input int i);
        return 32'hD00D_0000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Zero-wait slave; optional error address, mute mode, and junk ack/err while stb is low.
    always_comb begin
        ack   = 1'b0;
        err   = 1'b0;
        dat_r = rdata(adr);
        if (cyc && stb) begin
            if (!slv_never) begin
                if (slv_err_en && adr == slv_err_adr) err = 1'b1;
                else                                  ack = 1'b1;
            end
        end else if (slv_noise) begin
            ack = 1'b1;
            err = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc && stb && ack && !err) begin
                if (exp_adr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected beat: adr 0x%0h, expected no beat", adr);
                end else begin
                    mon_adr = exp_adr_q.pop_front();
                    mon_dat = exp_dat_q.pop_front();
                    check("beat adr", 64'(adr), 64'(mon_adr));
                    check("beat sel", 64'(sel), 64'hF);
                    if (we) begin
                        check("wr_ready", 64'(wr_ready), 64'd1);
                        check("dat_w", 64'(dat_w), 64'(mon_dat));
                    end else begin
                        check("rd_valid", 64'(rd_valid), 64'd1);
                        check("rd_data", 64'(rd_data), 64'(mon_dat));
                    end
                end
            end else begin
                check("no stream qualifier", 64'({rd_valid, wr_ready}), 64'd0);
            end
        end
    end

    task automatic run_xfer(input vec_t v, input int gap_beat, input int gap_cyc,
                            input int exp_stall, input logic noise);
        int   k = 0;
        int   stall = 0;
        int   cyc_n = 0;
        int   stb_low_n = 0;
        int   budget = 0;
        bit   seen_done = 0;
        logic [31:0] a;
        for (int i = 0; i < v.exp_beats; i++) begin
            a = v.addr + 32'(4 * i);
            exp_adr_q.push_back(a);
            exp_dat_q.push_back(v.we ? wdata(i) : rdata(a));
        end
        slv_never   = v.never;
        slv_err_en  = v.err_en;
        slv_err_adr = v.err_adr;
        slv_noise   = noise;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_len   = v.len;
        req_we    = v.we;
        wr_valid  = v.we && !(gap_beat == 0 && gap_cyc > 0);
        wr_data   = wdata(0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!seen_done && budget < 200) begin
            @(negedge clk);
            if (cyc) cyc_n++;
            if (cyc && !stb) stb_low_n++;
            if (wr_ready) k++;
            else if (cyc && !stb && k == gap_beat) stall++;
            if (done) begin
                seen_done = 1;
                check("status at done", 64'(status), 64'(v.exp_status));
                check("cyc low at done", 64'({cyc, stb}), 64'd0);
            end
            @(posedge clk); #1;
            if (!seen_done) begin
                wr_valid = v.we && !(k == gap_beat && stall < gap_cyc);
                wr_data  = wdata(k);
            end
            budget++;
        end
        if (!seen_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done timeout: no done within 200 cycles, expected done");
        end
        check("cyc cycles", 64'(cyc_n), 64'(v.exp_cyc));
        check("stb low cycles", 64'(stb_low_n), 64'(exp_stall));
        check("beats left", 64'(exp_adr_q.size()), 64'd0);
        check("done one cycle", 64'(done), 64'd0);
        check("ready after done", 64'(req_ready), 64'd1);
        check("status held", 64'(status), 64'(v.exp_status));
        $display("xfer addr=0x%08h len=%0d we=%0d status=%02b cyc_cycles=%0d",
                 v.addr, v.len, v.we, status, cyc_n);
        wr_valid  = 1'b0;
        slv_noise = 1'b0;
        exp_adr_q.delete();
        exp_dat_q.delete();
    endtask

    initial begin
        vec_t g;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst cyc/stb/we", 64'({cyc, stb, we}), 64'd0);
        check("rst qualifiers", 64'({rd_valid, wr_ready, done}), 64'd0);
        check("rst adr", 64'(adr), 64'd0);
        check("rst dat_w/sel", 64'({dat_w, sel}), 64'd0);
        check("rst status", 64'(status), 64'd0);
        rst_n = 1'b1;

        //          addr          len  we  err  err_adr       never st     beats cyc
        vecs[0] = '{32'h0000_1000, 16'd4, 1'b0, 1'b0, 32'h0,          1'b0, 2'b00, 4, 4};
        vecs[1] = '{32'h0000_2000, 16'd5, 1'b0, 1'b1, 32'h0000_2008,  1'b0, 2'b01, 2, 3};
        vecs[2] = '{32'h0000_7000, 16'd3, 1'b0, 1'b0, 32'h0,          1'b1, 2'b10, 0, TO};
        vecs[3] = '{32'hFFFF_FFFC, 16'd2, 1'b0, 1'b0, 32'h0,          1'b0, 2'b00, 2, 2};
        vecs[4] = '{32'h0000_8000, 16'd0, 1'b0, 1'b0, 32'h0,          1'b0, 2'b00, 0, 0};
        vecs[5] = '{32'h0000_3000, 16'd3, 1'b1, 1'b0, 32'h0,          1'b0, 2'b00, 3, 3};
        vecs[6] = '{32'h0000_4000, 16'd4, 1'b1, 1'b1, 32'h0000_4004,  1'b0, 2'b01, 1, 2};
        vecs[7] = '{32'h0000_9000, 16'd2, 1'b1, 1'b0, 32'h0,          1'b1, 2'b10, 0, TO};

        for (int i = 0; i < 8; i++) run_xfer(vecs[i], -1, 0, 0, 1'b0);

        // Write with a two-cycle data gap before the second beat; junk ack/err while stb is low.
        g = '{32'h0000_6000, 16'd3, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 3, 5};
        run_xfer(g, 1, 2, 2, 1'b1);

        // Reset during beat 2 of an 8-beat read.
        slv_never  = 1'b0;
        slv_err_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_adr_q.push_back(32'h0000_5000 + 32'(4 * i));
            exp_dat_q.push_back(rdata(32'h0000_5000 + 32'(4 * i)));
        end
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_5000;
        req_len   = 16'd8;
        req_we    = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        check("beat2 in flight", 64'({cyc, stb}), 64'd3);
        rst_n = 1'b0;
        #1;
        check("async drop cyc/stb", 64'({cyc, stb}), 64'd0);
        check("no done on reset", 64'(done), 64'd0);
        check("idle on reset", 64'(req_ready), 64'd1);
        exp_adr_q.delete();
        exp_dat_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("no done in reset", 64'({done, cyc}), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("xfer reset mid-transfer addr=0x00005000 len=8");

        g = '{32'h0000_A000, 16'd3, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 3, 3};
        run_xfer(g, -1, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_xfer_initiator.md
WB_XFER_INITIATOR -- requirements
Module: wb_xfer_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width; SEL width = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 256, maximum cycles to wait for ack or err per beat.
REQ-004 One clock; reset is asynchronous and active-low. Ports: clock input 1, rising-edge clock; reset input 1, asynchronous active-low reset.
REQ-005 Ports: req_valid input 1, transfer request; req_ready output 1, request accepted when both high.
REQ-006 Ports: req_addr input ADDR_WIDTH, byte start address, word-aligned; req_len input 16, beat count (0 = no bus activity); req_we input 1, 1 = write.
REQ-007 Ports: wr_data input DATA_WIDTH, write stream; wr_valid input 1; wr_ready output 1.
REQ-008 Ports: rd_data output DATA_WIDTH, read stream; rd_valid output 1, one-cycle qualifier with no backpressure.
REQ-009 Ports: done output 1, one-cycle completion pulse; status output 2, 00 ok / 01 bus err / 10 timeout, held until next done.
REQ-010 Ports: adr output ADDR_WIDTH; dat_w output DATA_WIDTH; dat_r input DATA_WIDTH; cyc, stb, we outputs 1; sel output SEL width; ack, err inputs 1 (Wishbone classic initiator side, drives the bus addr lines).

Function
REQ-011 FSM states SHALL be IDLE, BUS, DONE.
REQ-012 IDLE: req_ready = 1; on handshake, latch addr/len/we, clear beat counter; go DONE if req_len = 0, else BUS.
REQ-013 BUS: cyc = 1 throughout; sel = all ones; we = latched req_we; adr = current address.
REQ-014 Read beat: stb = 1 until ack; on ack, rd_data = dat_r and rd_valid = 1 in the same cycle.
REQ-015 Write beat: stb = wr_valid, dat_w = wr_data; wr_ready = ack & stb; stb never asserted without valid data.
REQ-016 On ack: address += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH, no error); beat counter += 1; after beat req_len, cyc drops the next cycle and FSM goes DONE.
REQ-017 Back-to-back beats SHALL hold stb high with no idle cycle (1 beat per cycle at zero-wait-state slave).
REQ-018 err during stb SHALL terminate: no rd_valid/wr_ready that cycle, status = 01, go DONE.
REQ-019 Timeout counter counts cycles with stb = 1 and no ack/err, clears on each ack; at TIMEOUT, status = 10, go DONE. Write stalls (wr_valid = 0) SHALL NOT count.
REQ-020 ack and err in the same cycle SHALL be treated as err.
REQ-021 DONE: done = 1 for one cycle, cyc = stb = 0, return IDLE; req_ready = 0 in BUS and DONE.
REQ-022 ack/err received outside stb SHALL be ignored.

Reset
REQ-023 While reset = 0: state IDLE; cyc, stb, we, rd_valid, wr_ready, done = 0; adr, dat_w, sel = 0; status = 00; counters 0.
REQ-024 Reset asserted mid-transfer SHALL drop cyc/stb asynchronously, with no done pulse.

Structure
REQ-025 State encoding and status codes SHALL live in shared package wb_xfer_pkg.
REQ-026 Timeout counter SHALL be sub-module wb_xfer_timeout (load/clear, count enable, expire flag).

Verification
REQ-027 Read, addr 0x1000, len 4, zero-wait slave -> adr 0x1000/04/08/0C on consecutive cycles, 4 rd_valid pulses, done, status 00.
REQ-028 Write, len 3, wr_valid low for 2 cycles before beat 2 -> stb low for those 2 cycles, cyc stays high, 3 wr_ready, status 00.
REQ-029 Read, len 5, slave asserts err on beat 3 -> 2 rd_valid pulses, done, status 01, cyc low the next cycle.
REQ-030 Slave never acks, TIMEOUT = 16 -> done after 16 stb cycles, status 10.
REQ-031 addr 0xFFFFFFFC, len 2 -> second adr 0x00000000; len 0 -> done without cyc.
REQ-032 Reset asserted during beat 2 of len 8 -> cyc/stb low immediately; next request after release runs normally.
